// File: rtl/shift_pattern_pkg.sv
// Shared definitions for the one-hot shift counter and its checker.
//   fsm_t   : checker phase-tracking states
//   period(): sequence length for a given hold count
//   dec()   : state index -> expected 8-bit one-hot pattern
package shift_pattern_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } fsm_t;

  // Seven left shifts, six right shifts and the closing 8'h01.
  localparam int unsigned RAMP_LEN = 14;

  function automatic int unsigned period(input int unsigned hold);
    return hold + RAMP_LEN;
  endfunction

  function automatic logic [7:0] dec(input logic [4:0] state, input int unsigned hold);
    int unsigned s;
    s = 32'(state);
    if (s < hold)                return 8'h01;
    else if (s < hold + 32'd7)   return 8'h01 << (s - hold + 32'd1);
    else if (s < hold + 32'd13)  return 8'h80 >> (s - hold - 32'd6);
    else if (s == hold + 32'd13) return 8'h01;
    else                         return 8'h00;
  endfunction

endpackage

// File: rtl/shift_state_decoder.sv
// Combinational state-index to pattern decoder.
//   i_state   : 5-bit sequence index
//   o_pattern : expected one-hot pattern for that index
module shift_state_decoder
  import shift_pattern_pkg::*;
#(
  parameter int unsigned HOLD = 4
) (
  input  logic [4:0] i_state,
  output logic [7:0] o_pattern
);

  always_comb o_pattern = dec(i_state, HOLD);

endmodule

// File: rtl/shift_pattern_checker.sv
// Receive-side checker for the bouncing one-hot shift counter.
// Locks onto the generator phase from the unique 01->02 transition, then
// flywheels the expected index and flags/counts mismatches.
//   clk, reset  : clock, asynchronous active-high reset
//   pattern     : sampled one-hot pattern
//   clear_err   : synchronous clear of err_count
//   locked      : phase lock established
//   state_idx   : index of the last compared sample
//   err_pulse   : last sample mismatched while locked
//   err_count   : saturating count of err_pulse events
module shift_pattern_checker
  import shift_pattern_pkg::*;
#(
  parameter int unsigned HOLD         = 4,
  parameter int unsigned LOCK_MATCHES = 4,
  parameter int unsigned LOSS_MISSES  = 3,
  parameter int unsigned ERR_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       pattern,
  input  logic             clear_err,
  output logic             locked,
  output logic [4:0]       state_idx,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned PER = period(HOLD);
  localparam int unsigned MW  = $clog2(LOCK_MATCHES + 1);
  localparam int unsigned LW  = $clog2(LOSS_MISSES + 1);

  fsm_t             r_state,     w_state_nx;
  logic [7:0]       r_prev_p;
  logic [4:0]       r_pred,      w_pred_nx;
  logic [4:0]       r_state_idx, w_idx_nx;
  logic [MW-1:0]    r_match_cnt, w_match_nx;
  logic [LW-1:0]    r_miss_cnt,  w_miss_nx;
  logic             r_locked;
  logic             r_err_pulse, w_pulse_nx;
  logic [ERR_W-1:0] r_err_count, w_cnt_nx;

  logic [7:0]       w_exp_pat;
  logic [4:0]       w_pred_inc;
  logic             w_hit;

  shift_state_decoder #(
    .HOLD (HOLD)
  ) u_dec (
    .i_state   (r_pred),
    .o_pattern (w_exp_pat)
  );

  assign w_hit      = (pattern == w_exp_pat);
  assign w_pred_inc = (r_pred == 5'(PER - 1)) ? '0 : r_pred + 5'd1;

  always_comb begin
    w_state_nx = r_state;
    w_pred_nx  = r_pred;
    w_idx_nx   = r_state_idx;
    w_match_nx = r_match_cnt;
    w_miss_nx  = r_miss_cnt;
    w_pulse_nx = 1'b0;
    w_cnt_nx   = r_err_count;

    unique case (r_state)
      HUNT: begin
        // 01->02 occurs only at s=HOLD-1 -> HOLD, so it pins the phase.
        if (r_prev_p == 8'h01 && pattern == 8'h02) begin
          w_idx_nx   = 5'(HOLD);
          w_pred_nx  = 5'(HOLD + 1);
          w_match_nx = MW'(1);
          w_miss_nx  = '0;
          w_state_nx = (LOCK_MATCHES == 1) ? LOCKED : SYNC;
        end
      end
      SYNC: begin
        if (w_hit) begin
          w_match_nx = r_match_cnt + MW'(1);
          w_idx_nx   = r_pred;
          w_pred_nx  = w_pred_inc;
          if (32'(r_match_cnt) + 32'd1 == LOCK_MATCHES) begin
            w_state_nx = LOCKED;
          end
        end else begin
          w_state_nx = HUNT;
          w_match_nx = '0;
          w_miss_nx  = '0;
        end
      end
      LOCKED: begin
        // Flywheel: the prediction advances whether or not the sample matched.
        w_idx_nx  = r_pred;
        w_pred_nx = w_pred_inc;
        if (w_hit) begin
          w_miss_nx = '0;
        end else begin
          w_pulse_nx = 1'b1;
          if (r_err_count != '1) begin
            w_cnt_nx = r_err_count + ERR_W'(1);
          end
          w_miss_nx = r_miss_cnt + LW'(1);
          if (32'(r_miss_cnt) + 32'd1 == LOSS_MISSES) begin
            w_state_nx = HUNT;
            w_miss_nx  = '0;
            w_match_nx = '0;
          end
        end
      end
      default: begin
        w_state_nx = HUNT;
      end
    endcase

    // Clear wins over a same-cycle error; the pulse is still reported.
    if (clear_err) begin
      w_cnt_nx = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= HUNT;
      r_prev_p    <= '0;
      r_pred      <= '0;
      r_state_idx <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_prev_p    <= pattern;
      r_pred      <= w_pred_nx;
      r_state_idx <= w_idx_nx;
      r_match_cnt <= w_match_nx;
      r_miss_cnt  <= w_miss_nx;
      r_locked    <= (w_state_nx == LOCKED);
      r_err_pulse <= w_pulse_nx;
      r_err_count <= w_cnt_nx;
    end
  end

  assign locked    = r_locked;
  assign state_idx = r_state_idx;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule
